dvs_event_fifo: RTL and testbench

Parametrised synchronous FIFO for buffering OpenDVS event words between the pixel-array readout and downstream packet/serializer logic. It supports any depth ≥ 2 (not only powers of two), uses the full `DEPTH` capacity, and has programmable almost-full/almost-empty thresholds. The read port is selectable between first-word-fall-through and registered-read modes. It also provides sticky overflow/underflow error flags, a synchronous flush and a high-water-mark counter for occupancy profiling.

---
 rtl/dvs_event_fifo_if.sv | 37 +++
 rtl/dvs_event_fifo.sv | 136 +++++++++++++
 tb/tb_dvs_event_fifo.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dvs_event_fifo_if.sv
// Event FIFO port bundle: write side, read side, control and status.
// slave faces the FIFO; master faces producer/consumer logic.
`timescale 1ns/1ps
interface dvs_event_fifo_if #(
  parameter int DWIDTH = 136,
  parameter int CW     = 5
);
  logic              flush;
  logic              clr_err;
  logic              wr_en;
  logic [DWIDTH-1:0] wdata;
  logic              rd_en;
  logic [DWIDTH-1:0] rdata;
  logic              rvalid;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [CW-1:0]     count;
  logic [CW-1:0]     hwm;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  flush, clr_err, wr_en, wdata, rd_en,
    output rdata, rvalid, empty, full,
    output almost_empty, almost_full,
    output count, hwm, overflow, underflow
  );

  modport master (
    output flush, clr_err, wr_en, wdata, rd_en,
    input  rdata, rvalid, empty, full,
    input  almost_empty, almost_full,
    input  count, hwm, overflow, underflow
  );
endinterface

// File: rtl/dvs_event_fifo.sv
// Synchronous FIFO for DVS event words, any depth >= 2.
// Status decoded from registered count; FWFT or registered read.
`timescale 1ns/1ps
module dvs_event_fifo #(
  parameter int DWIDTH        = 136,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 1,
  parameter int CW            = $clog2(DEPTH + 1)
) (
  input logic           clk,
  input logic           rst_n,
  dvs_event_fifo_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] hwm_q, hwm_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic empty;
  logic full;
  logic wr_acc;
  logic rd_acc;

  // Explicit wrap keeps non-power-of-two depths correct
  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign wr_acc = bus.wr_en && !full && !bus.flush;
  assign rd_acc = bus.rd_en && !empty && !bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (1'b1)
      bus.flush: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
      default: begin
        if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (wr_acc && !rd_acc) count_d = count_q + CW'(1);
        if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
      end
    endcase
  end

  // A new error in the clearing cycle must not be lost
  always_comb begin
    ovf_d = ovf_q && !bus.clr_err;
    udf_d = udf_q && !bus.clr_err;
    if (bus.wr_en && full && !bus.flush)  ovf_d = 1'b1;
    if (bus.rd_en && empty && !bus.flush) udf_d = 1'b1;
  end

  always_comb begin
    hwm_d = hwm_q;
    if (bus.clr_err)         hwm_d = count_d;
    else if (count_d > hwm_q) hwm_d = count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hwm_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hwm_q    <= hwm_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.wdata;
  end

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign bus.count        = count_q;
  assign bus.hwm          = hwm_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  if (FWFT != 0) begin : g_fwft
    assign bus.rdata  = mem[rd_ptr_q];
    assign bus.rvalid = !empty;
  end else begin : g_reg
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rd_acc;
      if (rd_acc) rdata_d = mem[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end

endmodule

// File: tb/tb_dvs_event_fifo.sv
// Directed bench: three FIFO configurations sharing clock and reset.
// u0 depth 16 FWFT, u1 depth 5 FWFT, u2 depth 16 registered read.
`timescale 1ns/1ps
module tb_dvs_event_fifo;

  logic clk;
  logic rst_n;
  int   nerr;
  int   nchk;

  dvs_event_fifo_if #(.DWIDTH(136), .CW(5)) b0 ();
  dvs_event_fifo_if #(.DWIDTH(8),   .CW(3)) b1 ();
  dvs_event_fifo_if #(.DWIDTH(8),   .CW(5)) b2 ();

  dvs_event_fifo #(
    .DWIDTH(136), .DEPTH(16), .AFULL_THRESH(12),
    .AEMPTY_THRESH(2), .FWFT(1)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  dvs_event_fifo #(
    .DWIDTH(8), .DEPTH(5), .AFULL_THRESH(4),
    .AEMPTY_THRESH(1), .FWFT(1)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  dvs_event_fifo #(
    .DWIDTH(8), .DEPTH(16), .AFULL_THRESH(12),
    .AEMPTY_THRESH(2), .FWFT(0)
  ) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [135:0] obs,
    input logic [135:0] exp
  );
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nerr = 0;
    nchk = 0;
    rst_n = 1'b0;
    b0.flush = 0; b0.clr_err = 0; b0.wr_en = 0;
    b0.rd_en = 0; b0.wdata = '0;
    b1.flush = 0; b1.clr_err = 0; b1.wr_en = 0;
    b1.rd_en = 0; b1.wdata = '0;
    b2.flush = 0; b2.clr_err = 0; b2.wr_en = 0;
    b2.rd_en = 0; b2.wdata = '0;
    #12;
    chk("rst_count", b0.count, 0);
    chk("rst_hwm", b0.hwm, 0);
    chk("rst_empty", b0.empty, 1);
    chk("rst_full", b0.full, 0);
    chk("rst_aempty", b0.almost_empty, 1);
    chk("rst_afull", b0.almost_full, 0);
    chk("rst_ovf", b0.overflow, 0);
    chk("rst_udf", b0.underflow, 0);
    chk("rst_rvalid", b0.rvalid, 0);
    chk("rst_reg_rvalid", b2.rvalid, 0);
    chk("rst_reg_rdata", b2.rdata, 0);
    rst_n = 1'b1;
    cyc();

    // single word
    b0.wr_en = 1; b0.wdata = 136'h0A5;
    cyc();
    b0.wr_en = 0;
    chk("sw_empty", b0.empty, 0);
    chk("sw_rvalid", b0.rvalid, 1);
    chk("sw_rdata", b0.rdata, 136'h0A5);
    chk("sw_count", b0.count, 1);
    b0.rd_en = 1;
    cyc();
    b0.rd_en = 0;
    chk("sw_pop_empty", b0.empty, 1);
    chk("sw_pop_count", b0.count, 0);
    chk("sw_pop_udf", b0.underflow, 0);

    // fill, overflow, ordering
    for (int i = 0; i < 16; i++) begin
      b0.wr_en = 1; b0.wdata = 136'(i);
      cyc();
      chk("fill_count", b0.count, 136'(i + 1));
      chk("fill_afull", b0.almost_full, (i + 1 >= 12));
    end
    b0.wdata = 136'd99;
    cyc();
    b0.wr_en = 0;
    chk("ovf_full", b0.full, 1);
    chk("ovf_count", b0.count, 16);
    chk("ovf_flag", b0.overflow, 1);
    chk("ovf_hwm", b0.hwm, 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", b0.rdata, 136'(i));
      chk("drain_aempty", b0.almost_empty, (16 - i <= 2));
      b0.rd_en = 1;
      cyc();
    end
    b0.rd_en = 0;
    chk("drain_empty", b0.empty, 1);
    chk("drain_udf", b0.underflow, 0);

    // flush and error clearing
    b0.clr_err = 1;
    cyc();
    b0.clr_err = 0;
    chk("clr_ovf", b0.overflow, 0);
    chk("clr_hwm", b0.hwm, 0);
    for (int i = 0; i < 8; i++) begin
      b0.wr_en = 1; b0.wdata = 136'(16 + i);
      cyc();
    end
    chk("pre_flush_count", b0.count, 8);
    b0.flush = 1; b0.wdata = 136'd77;
    cyc();
    b0.flush = 0; b0.wr_en = 0;
    chk("flush_count", b0.count, 0);
    chk("flush_empty", b0.empty, 1);
    chk("flush_hwm", b0.hwm, 8);
    b0.rd_en = 1;
    cyc();
    b0.rd_en = 0;
    chk("udf_set", b0.underflow, 1);
    chk("udf_count", b0.count, 0);
    b0.rd_en = 1; b0.clr_err = 1;
    cyc();
    b0.rd_en = 0;
    chk("udf_set_wins", b0.underflow, 1);
    cyc();
    b0.clr_err = 0;
    chk("udf_clr", b0.underflow, 0);
    chk("udf_clr_hwm", b0.hwm, 0);

    // non-power-of-two wrap
    b1.wr_en = 1; b1.wdata = 8'd100;
    cyc();
    for (int i = 0; i < 20; i++) begin
      chk("wrap_data", b1.rdata, 136'(100 + i));
      b1.wr_en = 1; b1.rd_en = 1;
      b1.wdata = 8'(101 + i);
      cyc();
      chk("wrap_count", b1.count, 1);
    end
    b1.wr_en = 0; b1.rd_en = 0;
    chk("wrap_hwm", b1.hwm, 1);
    chk("wrap_last", b1.rdata, 120);

    // registered read
    for (int i = 1; i <= 3; i++) begin
      b2.wr_en = 1; b2.wdata = 8'(i);
      cyc();
    end
    b2.wr_en = 0;
    chk("reg_idle_rvalid", b2.rvalid, 0);
    for (int i = 1; i <= 3; i++) begin
      b2.rd_en = 1;
      cyc();
      chk("reg_rvalid", b2.rvalid, 1);
      chk("reg_rdata", b2.rdata, 136'(i));
    end
    b2.rd_en = 0;
    cyc();
    chk("reg_rvalid_drop", b2.rvalid, 0);
    chk("reg_rdata_hold", b2.rdata, 3);

    // asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) begin
      b0.wr_en = 1; b0.wdata = 136'(40 + i);
      cyc();
    end
    b0.wr_en = 0;
    chk("ar_count_pre", b0.count, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", b0.count, 0);
    chk("ar_hwm", b0.hwm, 0);
    chk("ar_empty", b0.empty, 1);
    chk("ar_aempty", b0.almost_empty, 1);
    chk("ar_rvalid", b0.rvalid, 0);
    chk("ar_reg_rdata", b2.rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    b0.wr_en = 1; b0.wdata = 136'h3C;
    cyc();
    b0.wr_en = 0;
    chk("ar_post_rdata", b0.rdata, 136'h3C);
    chk("ar_post_count", b0.count, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
